// File: rtl/spi_slave_endpoint.sv
// spi_slave_endpoint: SPI mode-0 slave, oversampled in the HCLK domain.
// Presents each received byte locally and returns bytes from a one-deep TX holding register.
module spi_slave_endpoint #(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_ss_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       underrun_o,
  output logic       abort_o,
  output logic       busy_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Index 0 samples the pin, index 1 is the synchronized level, index 2 is its delayed copy.
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= 3'b111;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk_i};
      ss_sync   <= {ss_sync[1:0], spi_ss_n_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
    end
  end

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s2;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign mosi_s2   = mosi_sync[1];

  state_t     state;
  logic [7:0] tx_hold;
  logic       tx_full;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       byte_done;

  logic [2:0] cnt_inc;
  logic [7:0] rx_next;
  logic [7:0] reload_byte;
  logic       abort_cond;

  assign cnt_inc     = bit_cnt + 3'd1;
  assign rx_next     = {rx_shift[6:0], mosi_s2};
  assign reload_byte = tx_full ? tx_hold : FILL_BYTE;
  // A sample landing with the select release counts first; only a still-partial byte aborts.
  assign abort_cond  = sclk_rise ? (cnt_inc != 3'd0) : (bit_cnt != 3'd0);
  assign tx_ready_o  = ~tx_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tx_hold    <= 8'h00;
      tx_full    <= 1'b0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_done  <= 1'b0;
      spi_miso_o <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;

      // Load and consume never coincide: loads need ~full, consumes need full.
      if (tx_valid_i && !tx_full) begin
        tx_hold <= tx_data_i;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt    <= 3'd0;
          byte_done  <= 1'b0;
          spi_miso_o <= 1'b0;
          if (ss_fall) begin
            tx_shift   <= reload_byte;
            spi_miso_o <= reload_byte[7];
            if (tx_full) tx_full <= 1'b0;
            else         underrun_o <= 1'b1;
            state  <= ACTIVE;
            busy_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= cnt_inc;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= rx_next;
              rx_valid_o <= 1'b1;
              byte_done  <= 1'b1;
            end
          end
          if (ss_rise) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            spi_miso_o <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            if (abort_cond) abort_o <= 1'b1;
          end else if (sclk_fall) begin
            if (byte_done) begin
              tx_shift   <= reload_byte;
              spi_miso_o <= reload_byte[7];
              byte_done  <= 1'b0;
              if (tx_full) tx_full <= 1'b0;
              else         underrun_o <= 1'b1;
            end else begin
              tx_shift   <= {tx_shift[6:0], 1'b0};
              spi_miso_o <= tx_shift[6];
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// tb_spi_slave_endpoint: mode-0 SPI master driving the endpoint through a table of frames,
// hand-written corner sequences and random frames checked against a byte-level model.
`timescale 1ns/1ps
module tb_spi_slave_endpoint;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk, spi_ss_n, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       underrun, abort_p, busy;

  always #5 clk = ~clk;

  spi_slave_endpoint dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .spi_clk_i  (spi_clk),
    .spi_ss_n_i (spi_ss_n),
    .spi_mosi_i (spi_mosi),
    .spi_miso_o (spi_miso),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .underrun_o (underrun),
    .abort_o    (abort_p),
    .busy_o     (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor and scoreboard capture, sampled on the falling clock edge.
  int n_rxv = 0, n_und = 0, n_abort = 0, width_err = 0;
  logic prev_rxv = 1'b0, prev_und = 1'b0, prev_abt = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      got_q.push_back(rx_data);
    end
    if (underrun) n_und++;
    if (abort_p) n_abort++;
    if ((rx_valid && prev_rxv) || (underrun && prev_und) || (abort_p && prev_abt)) width_err++;
    prev_rxv = rx_valid;
    prev_und = underrun;
    prev_abt = abort_p;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    if (tx_ready) begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  // One frame of n bytes; sup[i] says whether return byte i is offered before its boundary.
  task automatic run_frame(input int n, input logic [31:0] mosi_w, input logic [31:0] tx_w,
                           input logic [3:0] sup, output logic [31:0] miso_w);
    logic [7:0] mb;
    miso_w = 32'd0;
    if (sup[0]) load_tx(tx_w[8*(n-1) +: 8]);
    spi_ss_n = 1'b0;
    clk_wait(8);
    for (int i = 0; i < n; i++) begin
      mb = mosi_w[8*(n-1-i) +: 8];
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = mb[b];
        clk_wait(4);
        spi_clk = 1'b1;
        miso_w = {miso_w[30:0], spi_miso};
        if (b == 0 && i < n-1 && sup[i+1]) load_tx(tx_w[8*(n-2-i) +: 8]);
        clk_wait(4);
        if (!(b == 0 && i == n-1)) spi_clk = 1'b0;
      end
    end
    spi_ss_n = 1'b1;
    clk_wait(4);
    spi_clk = 1'b0;
    clk_wait(8);
  endtask

  task automatic drain(input string tag);
    logic [7:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check({tag, "_rx_byte"}, {24'd0, g}, {24'd0, e});
    end
    check({tag, "_rx_extra"}, got_q.size(), 32'd0);
    got_q.delete();
  endtask

  task automatic do_frame(input string tag, input int n, input logic [31:0] mosi_w,
                          input logic [31:0] tx_w, input logic [3:0] sup,
                          input logic [31:0] exp_rx, input logic [31:0] exp_miso,
                          input int exp_und);
    int rx0, u0, a0;
    logic [31:0] got;
    rx0 = n_rxv;
    u0  = n_und;
    a0  = n_abort;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_rx[8*(n-1-i) +: 8]);
    run_frame(n, mosi_w, tx_w, sup, got);
    check({tag, "_miso"}, got, exp_miso);
    check({tag, "_rx_count"}, n_rxv - rx0, n);
    check({tag, "_underruns"}, n_und - u0, exp_und);
    check({tag, "_aborts"}, n_abort - a0, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_miso_after"}, {31'd0, spi_miso}, 32'd0);
    drain(tag);
    last_rx = exp_rx[7:0];
  endtask

  typedef struct {
    int          n;
    logic [31:0] mosi;
    logic [31:0] tx;
    logic [3:0]  sup;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
    int          exp_und;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rx0, a0, cnt;
    logic [7:0] mb;
    logic [31:0] r_mosi, r_tx, em;
    logic [3:0] r_sup;
    int r_n, eu;

    vecs[0] = '{1, 32'h0000_003C, 32'h0000_00A5, 4'b0001, 32'h0000_003C, 32'h0000_00A5, 0};
    vecs[1] = '{4, 32'hDEAD_BEEF, 32'h1122_3344, 4'b1111, 32'hDEAD_BEEF, 32'h1122_3344, 0};
    vecs[2] = '{2, 32'h0000_5AC3, 32'h0000_5500, 4'b0001, 32'h0000_5AC3, 32'h0000_5500, 1};
    vecs[3] = '{3, 32'h00FF_0180, 32'h0000_CAFE, 4'b0110, 32'h00FF_0180, 32'h0000_CAFE, 1};
    vecs[4] = '{2, 32'h0000_8001, 32'h0000_0000, 4'b0000, 32'h0000_8001, 32'h0000_0000, 2};

    rst = 1'b1; spi_clk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    clk_wait(3);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_miso", {31'd0, spi_miso}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_underrun", {31'd0, underrun}, 32'd0);
    check("reset_abort", {31'd0, abort_p}, 32'd0);
    rst = 1'b0;
    clk_wait(8);

    for (int i = 0; i < 5; i++)
      do_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].mosi, vecs[i].tx, vecs[i].sup,
               vecs[i].exp_rx, vecs[i].exp_miso, vecs[i].exp_und);

    // Select released on the same synchronized cycle as the eighth SCLK rise.
    rx0 = n_rxv; a0 = n_abort;
    mb = 8'h96;
    exp_q.push_back(8'h96);
    spi_ss_n = 1'b0;
    clk_wait(8);
    for (int b = 7; b >= 0; b--) begin
      spi_mosi = mb[b];
      clk_wait(4);
      if (b == 0) begin
        spi_clk  = 1'b1;
        spi_ss_n = 1'b1;
      end else begin
        spi_clk = 1'b1;
        clk_wait(4);
        spi_clk = 1'b0;
      end
    end
    clk_wait(8);
    check("coinc_rx_count", n_rxv - rx0, 32'd1);
    check("coinc_rx_data", {24'd0, rx_data}, 32'h96);
    check("coinc_aborts", n_abort - a0, 32'd0);
    check("coinc_busy", {31'd0, busy}, 32'd0);
    drain("coinc");
    last_rx = 8'h96;
    spi_clk = 1'b0;
    clk_wait(8);

    // Select released after five SCLK rises.
    rx0 = n_rxv; a0 = n_abort;
    mb = 8'hF3;
    spi_ss_n = 1'b0;
    clk_wait(8);
    for (int k = 0; k < 5; k++) begin
      spi_mosi = mb[7-k];
      clk_wait(4);
      spi_clk = 1'b1;
      clk_wait(4);
      if (k < 4) spi_clk = 1'b0;
    end
    spi_ss_n = 1'b1;
    clk_wait(6);
    check("abort_count", n_abort - a0, 32'd1);
    check("abort_rx_count", n_rxv - rx0, 32'd0);
    check("abort_rx_data", {24'd0, rx_data}, {24'd0, last_rx});
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_miso", {31'd0, spi_miso}, 32'd0);
    spi_clk = 1'b0;
    clk_wait(8);

    // Reset after three bits, with a return byte still waiting in the holding register.
    rx0 = n_rxv; a0 = n_abort;
    load_tx(8'h77);
    mb = 8'hE7;
    spi_ss_n = 1'b0;
    clk_wait(8);
    load_tx(8'h66);
    for (int k = 0; k < 3; k++) begin
      spi_mosi = mb[7-k];
      clk_wait(4);
      spi_clk = 1'b1;
      clk_wait(4);
      if (k < 2) spi_clk = 1'b0;
    end
    rst = 1'b1;
    spi_ss_n = 1'b1;
    clk_wait(1);
    check("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_mid_underrun", {31'd0, underrun}, 32'd0);
    check("rst_mid_abort", {31'd0, abort_p}, 32'd0);
    rst = 1'b0;
    spi_clk = 1'b0;
    clk_wait(8);
    check("rst_mid_no_abort", n_abort - a0, 32'd0);
    check("rst_mid_no_rx", n_rxv - rx0, 32'd0);
    last_rx = 8'h00;
    do_frame("post_reset", 2, 32'h0000_C35A, 32'h0000_A55A, 4'b0011,
             32'h0000_C35A, 32'h0000_A55A, 0);

    // Random frames against the byte-level model.
    for (int t = 0; t < 20; t++) begin
      r_n    = $urandom_range(1, 4);
      r_mosi = $urandom;
      r_tx   = $urandom;
      r_sup  = 4'($urandom_range(0, 15));
      em = 32'd0;
      eu = 0;
      cnt = 0;
      for (int i = 0; i < r_n; i++) begin
        em = {em[23:0], r_sup[i] ? r_tx[8*(r_n-1-i) +: 8] : 8'h00};
        if (!r_sup[i]) eu++;
        cnt++;
      end
      if (r_n < 4) begin
        r_mosi = r_mosi & ((32'd1 << (8*r_n)) - 32'd1);
        r_tx   = r_tx   & ((32'd1 << (8*r_n)) - 32'd1);
      end
      do_frame($sformatf("rand%0d", t), r_n, r_mosi, r_tx, r_sup, r_mosi, em, eu);
    end

    check("pulse_width_errors", width_err, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
